btn_ctrl: RTL and testbench
===========================

# btn_ctrl

Button front-end for the LED counter subsystem: synchronises and debounces two raw push-buttons and turns each clean press into a control change. One button cycles the speed-select code `SW[1:0]` (the clock-divider tap choice); the other toggles the count direction `UD`. Its outputs drive the speed-select and direction inputs of the LED counter directly, replacing board slide switches.

## Interface
- `DEB_CNT`, default 500000: consecutive stable cycles required to accept a new button level (10 ms at 50 MHz); must be ≥ 2.
- `DEB_W`, default 19: debounce counter width; must satisfy 2^DEB_W ≥ DEB_CNT.

- `clk`  in  1  system clock; all state is on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `BTN_SPD`  in  1  raw speed button, active-high, asynchronous to `clk`, may bounce.
- `BTN_DIR`  in  1  raw direction button, active-high, asynchronous to `clk`, may bounce.
- `SW`  out  2  speed-select code for the counter's clock mux.
- `UD`  out  1  count direction: 1 = up, 0 = down.
- `SPD_EVT`  out  1  one-cycle pulse on an accepted speed-button press.
- `DIR_EVT`  out  1  one-cycle pulse on an accepted direction-button press.

## Operation
- Reset (`reset` = 0, async): `SW` = 2'b00, `UD` = 1, `SPD_EVT` = `DIR_EVT` = 0. All synchroniser flops, stable levels and debounce counters go to 0.
- Per button, in an independent channel:
  - Two-flop synchroniser produces `sync`.
  - Debounce keeps a `stable` level and a counter `cnt`:
    - `sync == stable`: `cnt` <= 0.
    - `sync != stable` and `cnt < DEB_CNT-1`: `cnt` <= `cnt+1`.
    - `sync != stable` and `cnt == DEB_CNT-1`: `stable` <= `sync`, `cnt` <= 0.
  - A mismatch that ends early clears `cnt`, so bounces shorter than `DEB_CNT` cycles are rejected.
- Press event: asserted on the edge where `stable` goes 0→1, for exactly one cycle. A 1→0 transition (release) generates no event.
- Speed control: on `SPD_EVT`, `SW` <= `SW + 1` mod 4. The sequence is 00→01→10→11→00.
- Direction control: on `DIR_EVT`, `UD` <= ~`UD`.
- Simultaneous events: both apply on the same edge. The channels never block each other.
- Holding a button: one event only. A new event requires a debounced release followed by a debounced press.

## Timing
- Let edge c be the first edge at which sync flop 1 captures the new raw level, with raw held steady from then on.
- `stable` updates, and the event pulse rises, at edge c + DEB_CNT + 1. The pulse falls at the next edge.
- `SW`/`UD` change at edge c + DEB_CNT + 2, one edge after the pulse rises.
- Minimum press-to-output latency is therefore DEB_CNT + 2 clocks.
- Outputs are registered, with no combinational path from `BTN_*`.
- Reset mid-debounce discards the partial count. After reset release, a button already held high is accepted as a new press once it has been stable for the full debounce time.
- `cnt` never exceeds `DEB_CNT-1`, so there is no wrap-around.

## Structure
- Shared package holds:
  - `SW_W` = 2.
  - Reset constants `SW_RST` = 2'b00 and `UD_RST` = 1'b1.
  - Direction encodings `UD_UP` = 1 and `UD_DOWN` = 0.
- One sub-module, `btn_debounce`:
  - Parameters: `DEB_CNT`, `DEB_W`.
  - Ports: `clk`, `reset`, `btn`, `level`, `press`.
  - Contains the synchroniser, debounce counter and rising-edge pulse.
  - Instantiated twice.
- The top level holds only the `SW` and `UD` registers.

## Test plan
All scenarios use `DEB_CNT` = 4, `DEB_W` = 3.
- Reset: hold `reset` = 0 with buttons toggling → `SW` = 00, `UD` = 1, both EVT = 0 throughout. Release reset, idle 10 cycles → outputs unchanged.
- Clean press: `BTN_SPD` high for 20 cycles → exactly one `SPD_EVT` pulse at edge c+5. `SW` = 01 at c+6; no further change while held. Release → no event.
- Bounce rejection: `BTN_DIR` pulses of 1, 2 and 3 cycles separated by 1 low cycle, then low → no `DIR_EVT`, `UD` stays 1. Next, a 10-cycle hold → one event, `UD` = 0.
- Wrap-around: five clean `BTN_SPD` presses, each separated by 10 low cycles → `SW` goes 01, 10, 11, 00, 01.
- Simultaneous: both buttons rise on the same cycle and hold → `SPD_EVT` and `DIR_EVT` on the same edge. Starting from reset, `SW` = 01 and `UD` = 0 on the same following edge.
- Reset mid-operation: assert `reset` two cycles into a `BTN_SPD` hold, release one cycle later with the button still high → no event before DEB_CNT + 1 edges after release. Exactly one event after that, and `SW` = 01.

Source files
------------

// File: rtl/btn_ctrl_pkg.sv
// Shared constants for the button front-end.
// Reset values and encodings of the speed/direction controls.
package btn_ctrl_pkg;

    localparam int SW_W = 2;

    localparam logic [SW_W-1:0] SW_RST = 2'b00;
    localparam logic UD_UP = 1'b1;
    localparam logic UD_DOWN = 1'b0;
    localparam logic UD_RST = UD_UP;

endpackage

// File: rtl/btn_debounce.sv
// One button channel: two-flop synchroniser, debounce counter,
// and a registered one-cycle pulse on each accepted press.
module btn_debounce #(
    parameter int DEB_CNT = 500000,
    parameter int DEB_W = 19
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam logic [DEB_W-1:0] CNT_MAX = DEB_W'(DEB_CNT - 1);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic stable_q, stable_d;
    logic press_q, press_d;
    logic [DEB_W-1:0] cnt_q, cnt_d;

    // A new level is accepted only after DEB_CNT consecutive mismatching
    // cycles; any return to the stable level clears the count.
    always_comb begin
        s1_d = btn;
        s2_d = s1_q;
        stable_d = stable_q;
        cnt_d = '0;
        press_d = 1'b0;
        if (s2_q != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d = s2_q;
                press_d = s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            stable_q <= 1'b0;
            cnt_q <= '0;
            press_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            stable_q <= stable_d;
            cnt_q <= cnt_d;
            press_q <= press_d;
        end
    end

    assign level = stable_q;
    assign press = press_q;

endmodule

// File: rtl/btn_ctrl.sv
// Button front-end: speed button cycles SW, direction button toggles UD.
// Both channels are independent and may fire on the same edge.
module btn_ctrl
    import btn_ctrl_pkg::*;
#(
    parameter int DEB_CNT = 500000,
    parameter int DEB_W = 19
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            BTN_SPD,
    input  logic            BTN_DIR,
    output logic [SW_W-1:0] SW,
    output logic            UD,
    output logic            SPD_EVT,
    output logic            DIR_EVT
);

    logic spd_level, dir_level;
    logic unused_levels;
    logic [SW_W-1:0] sw_q, sw_d;
    logic ud_q, ud_d;

    btn_debounce #(
        .DEB_CNT(DEB_CNT),
        .DEB_W(DEB_W)
    ) u_spd (
        .clk(clk),
        .reset(reset),
        .btn(BTN_SPD),
        .level(spd_level),
        .press(SPD_EVT)
    );

    btn_debounce #(
        .DEB_CNT(DEB_CNT),
        .DEB_W(DEB_W)
    ) u_dir (
        .clk(clk),
        .reset(reset),
        .btn(BTN_DIR),
        .level(dir_level),
        .press(DIR_EVT)
    );

    assign unused_levels = spd_level ^ dir_level;

    // Apply each press one edge after its pulse; SW wraps mod 4.
    always_comb begin
        sw_d = sw_q;
        ud_d = ud_q;
        if (SPD_EVT) begin
            sw_d = sw_q + 1'b1;
        end
        if (DIR_EVT) begin
            ud_d = (ud_q == UD_UP) ? UD_DOWN : UD_UP;
        end
    end

    // Control registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_q <= SW_RST;
            ud_q <= UD_RST;
        end else begin
            sw_q <= sw_d;
            ud_q <= ud_d;
        end
    end

    assign SW = sw_q;
    assign UD = ud_q;

endmodule

// File: tb/tb_btn_ctrl.sv
// Bench for btn_ctrl: expected events are queued at stimulus time
// and popped by a monitor whenever an event pulse appears.
module tb_btn_ctrl;
    import btn_ctrl_pkg::*;

    localparam int DEB_CNT = 4;
    localparam int DEB_W = 3;
    localparam int LAT = DEB_CNT + 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic BTN_SPD = 1'b0;
    logic BTN_DIR = 1'b0;
    logic [1:0] SW;
    logic UD, SPD_EVT, DIR_EVT;

    typedef struct {
        int cyc;
        logic spd;
        logic dir;
        logic [1:0] sw;
        logic ud;
    } exp_t;

    exp_t q[$];
    exp_t pend;
    bit chk_pend = 0;
    int cyc = 0;
    int total = 0;
    int bad = 0;
    logic [1:0] exp_sw = SW_RST;
    logic exp_ud = UD_RST;

    btn_ctrl #(
        .DEB_CNT(DEB_CNT),
        .DEB_W(DEB_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .BTN_SPD(BTN_SPD),
        .BTN_DIR(BTN_DIR),
        .SW(SW),
        .UD(UD),
        .SPD_EVT(SPD_EVT),
        .DIR_EVT(DIR_EVT)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at cyc %0d",
                     name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_evt(input bit s, input bit d);
        exp_t e;
        if (s) exp_sw = exp_sw + 2'd1;
        if (d) exp_ud = ~exp_ud;
        e.cyc = cyc + LAT;
        e.spd = s;
        e.dir = d;
        e.sw = exp_sw;
        e.ud = exp_ud;
        q.push_back(e);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(2);
        check("sw in reset", SW, SW_RST);
        reset = 1'b1;
        exp_sw = SW_RST;
        exp_ud = UD_RST;
        step(1);
    endtask

    // Monitor: pop an expectation on every event pulse, and check the
    // control outputs on the following cycle.
    always @(negedge clk) begin
        exp_t e;
        if (chk_pend) begin
            check("sw after evt", SW, pend.sw);
            check("ud after evt", UD, pend.ud);
            chk_pend = 0;
        end
        if (SPD_EVT || DIR_EVT) begin
            if (q.size() == 0) begin
                check("unexpected evt", {SPD_EVT, DIR_EVT}, 0);
            end else begin
                e = q.pop_front();
                check("evt cycle", cyc, e.cyc);
                check("spd_evt", SPD_EVT, e.spd);
                check("dir_evt", DIR_EVT, e.dir);
                pend = e;
                chk_pend = 1;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with buttons toggling.
        for (int i = 0; i < 8; i++) begin
            BTN_SPD = i[0];
            BTN_DIR = i[1];
            step(1);
            check("rst sw", SW, SW_RST);
            check("rst ud", UD, UD_RST);
            check("rst evt", {SPD_EVT, DIR_EVT}, 0);
        end
        BTN_SPD = 1'b0;
        BTN_DIR = 1'b0;
        step(2);
        reset = 1'b1;
        step(10);
        check("idle sw", SW, SW_RST);
        check("idle ud", UD, UD_RST);

        // Clean press, long hold, release.
        expect_evt(1'b1, 1'b0);
        BTN_SPD = 1'b1;
        step(20);
        check("held sw", SW, exp_sw);
        BTN_SPD = 1'b0;
        step(12);
        check("released sw", SW, exp_sw);

        // Bounces of 1, 2, 3 cycles are rejected.
        for (int len = 1; len <= 3; len++) begin
            BTN_DIR = 1'b1;
            step(len);
            BTN_DIR = 1'b0;
            step(1);
        end
        step(10);
        check("bounce ud", UD, 1'b1);
        expect_evt(1'b0, 1'b1);
        BTN_DIR = 1'b1;
        step(10);
        BTN_DIR = 1'b0;
        step(12);
        check("dir ud", UD, 1'b0);

        // Five presses from reset wrap SW.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            expect_evt(1'b1, 1'b0);
            BTN_SPD = 1'b1;
            step(8);
            check("wrap sw", SW, exp_sw);
            BTN_SPD = 1'b0;
            step(10);
        end
        check("wrap final", SW, 2'b01);

        // Both buttons together.
        do_reset();
        expect_evt(1'b1, 1'b1);
        BTN_SPD = 1'b1;
        BTN_DIR = 1'b1;
        step(10);
        check("sim sw", SW, 2'b01);
        check("sim ud", UD, 1'b0);
        BTN_SPD = 1'b0;
        BTN_DIR = 1'b0;
        step(12);

        // Reset in the middle of a press.
        do_reset();
        BTN_SPD = 1'b1;
        step(2);
        reset = 1'b0;
        step(1);
        check("mid rst sw", SW, SW_RST);
        reset = 1'b1;
        exp_sw = SW_RST;
        exp_ud = UD_RST;
        expect_evt(1'b1, 1'b0);
        step(12);
        check("mid rst after", SW, 2'b01);
        BTN_SPD = 1'b0;
        step(12);

        step(5);
        check("queue empty", q.size(), 0);
        check("no pending", chk_pend, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
